// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant lasts one packet, MAX_BURST beats, or until IDLE_TIMEOUT idle cycles.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic                          wr_clk_i,
    input  logic                          wr_rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          busy_o
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [0:0] {StArb, StGrant} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

    logic [GW-1:0]   cand;
    logic            found;
    logic            cur_valid;
    logic            cur_last;
    logic            xfer;
    logic            release_grant;
    logic            wr_go;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        cand          = '0;
        found         = 1'b0;
        cur_valid     = req_valid_i[grant_q];
        cur_last      = req_last_i[grant_q];
        xfer          = 1'b0;
        release_grant = 1'b0;

        case (state_q)
            StArb: begin
                // Search starts one past the previous holder and wraps.
                for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                    cand = GW'((32'(last_grant_q) + k) % NUM_REQ);
                    if (!found && req_valid_i[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) begin
                    state_d    = StGrant;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            StGrant: begin
                xfer = cur_valid && !fifo_full_i;
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // Back-pressured cycles keep valid high, so they never count as idle.
                idle_cnt_d = cur_valid ? '0 : idle_cnt_q + 1'b1;
                if (xfer && (cur_last || beat_cnt_d == BW'(MAX_BURST))) begin
                    release_grant = 1'b1;
                end
                if (idle_cnt_d == IW'(IDLE_TIMEOUT)) begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    state_d      = StArb;
                    last_grant_d = grant_q;
                    beat_cnt_d   = '0;
                    idle_cnt_d   = '0;
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    always_comb begin
        wr_go          = xfer && wr_rst_ni;
        fifo_wr_en_o   = wr_go;
        req_ready_o    = '0;
        fifo_wr_data_o = '0;
        if (wr_go) begin
            req_ready_o[grant_q] = 1'b1;
            fifo_wr_data_o       = req_data_i[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign grant_id_o = grant_q;
    assign busy_o     = (state_q == StGrant);

    always_ff @(posedge wr_clk_i) begin
        if (!wr_rst_ni) begin
            state_q      <= StArb;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a transaction-level model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int TO = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      grant_id;
    logic            busy;

    fifo_wr_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .wr_clk_i       (clk),
        .wr_rst_ni      (rst_n),
        .req_valid_i    (req_valid),
        .req_last_i     (req_last),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .fifo_full_i    (fifo_full),
        .fifo_wr_en_o   (fifo_wr_en),
        .fifo_wr_data_o (fifo_wr_data),
        .grant_id_o     (grant_id),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] data;
    } beat_t;

    beat_t sb[$];

    int checks = 0;
    int errors = 0;

    // Requester streams: beats left in the current packet and a running sequence number.
    int rem [N];
    int seq [N];

    // Model of the port owner: -1 while arbitrating.
    int owner = -1;
    int ptr   = N - 1;
    int beats = 0;
    int idle  = 0;
    bit known = 0;

    bit mon_en      = 0;
    bit exp_wr_now  = 0;
    bit exp_busy    = 0;
    bit chk_busy    = 0;
    int exp_gid     = 0;

    task automatic model_step();
        bit rel;
        int o;
        rel      = 0;
        chk_busy = known;
        exp_busy = (owner >= 0);
        exp_gid  = owner;
        exp_wr_now = 0;
        if (!rst_n) begin
            owner = -1;
            ptr   = N - 1;
            beats = 0;
            idle  = 0;
            known = 1;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && req_valid[(ptr + k) % N]) begin
                    owner = (ptr + k) % N;
                    beats = 0;
                    idle  = 0;
                end
            end
        end else begin
            o = owner;
            if (req_valid[o] && !fifo_full) begin
                exp_wr_now = 1;
                sb.push_back('{id: o, data: req_data[o*DW +: DW]});
                beats++;
                if (req_last[o] || beats == MB) rel = 1;
                rem[o]--;
                seq[o]++;
            end
            if (req_valid[o]) idle = 0;
            else begin
                idle++;
                if (idle == TO) rel = 1;
            end
            if (rel) begin
                ptr   = o;
                owner = -1;
            end
        end
    endtask

    task automatic run_cycle(input int pv, input int pfull, input int maxlen, input int prst,
                             input bit force_rst);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && (pv == 100 || $urandom_range(0, 99) < 50))
                rem[i] = $urandom_range(1, maxlen);
            req_valid[i] = (rem[i] != 0) && ($urandom_range(0, 99) < pv);
            req_last[i]  = (rem[i] == 1);
            req_data[i*DW +: DW] = {4'(i), 12'(seq[i])};
        end
        fifo_full = ($urandom_range(0, 99) < pfull);
        rst_n     = !(force_rst || ($urandom_range(0, 99) < prst));
        model_step();
        mon_en = 1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            beat_t e;
            checks++;
            if (fifo_wr_en !== exp_wr_now) begin
                errors++;
                $display("FAIL wr_en: got %b expected %b at %0t", fifo_wr_en, exp_wr_now, $time);
            end
            if (fifo_wr_en === 1'b1) begin
                checks++;
                if (fifo_full !== 1'b0 || rst_n !== 1'b1) begin
                    errors++;
                    $display("FAIL write_gated: wr_en with full=%b rst_n=%b at %0t",
                             fifo_full, rst_n, $time);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: data %h, none expected at %0t",
                             fifo_wr_data, $time);
                end else begin
                    e = sb.pop_front();
                    if (fifo_wr_data !== e.data || req_ready !== 4'(1 << e.id)) begin
                        errors++;
                        $display("FAIL write_beat: data %h ready %b expected data %h ready %b at %0t",
                                 fifo_wr_data, req_ready, e.data, 4'(1 << e.id), $time);
                    end
                end
            end else begin
                checks++;
                if (req_ready !== '0 || fifo_wr_data !== '0) begin
                    errors++;
                    $display("FAIL idle_outputs: ready %b data %h expected 0 at %0t",
                             req_ready, fifo_wr_data, $time);
                end
            end
            if (chk_busy) begin
                checks++;
                if (busy !== exp_busy) begin
                    errors++;
                    $display("FAIL busy: got %b expected %b at %0t", busy, exp_busy, $time);
                end
                if (exp_busy) begin
                    checks++;
                    if (int'(grant_id) != exp_gid) begin
                        errors++;
                        $display("FAIL grant_id: got %0d expected %0d at %0t",
                                 grant_id, exp_gid, $time);
                    end
                end
            end
        end
    end

    int ph_cyc [6] = '{200, 300, 400, 400, 400, 300};
    int ph_pv  [6] = '{100, 100, 70, 40, 80, 15};
    int ph_pf  [6] = '{0, 0, 30, 10, 20, 0};
    int ph_len [6] = '{2, 12, 6, 12, 8, 3};
    int ph_rst [6] = '{0, 0, 0, 0, 2, 0};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        // Reset held with every requester valid.
        for (int c = 0; c < 3; c++) run_cycle(100, 0, 2, 0, 1'b1);
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < ph_cyc[p]; c++)
                run_cycle(ph_pv[p], ph_pf[p], ph_len[p], ph_rst[p], 1'b0);
        end
        @(negedge clk);
        #1;
        mon_en = 0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: %0d beats left in scoreboard, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter in front of the async FIFO write interface, in the write clock domain. It shares the FIFO's single write port among NUM_REQ requesters. Once granted, a requester keeps the port for a whole packet (up to MAX_BURST beats), and a stalled requester releases it after a timeout. The block drives the FIFO's `wr_en`/`wr_data` directly and honours the FIFO's combinational `full` flag.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, 16: beat width; must equal the FIFO's DATA_WIDTH.
- `MAX_BURST`, 8: maximum beats per grant before forced re-arbitration; legal range 1..255.
- `IDLE_TIMEOUT`, 16: consecutive cycles the granted requester may hold `req_valid` low before the grant is released; legal range 1..255.
- `wr_clk`  in  1  write-domain clock; the only clock.
- `wr_rst_n`  in  1  synchronous, active-low reset; sampled on rising `wr_clk`.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_last`  in  NUM_REQ  per-requester last beat of packet; qualified by `req_valid`.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  beat accepted this cycle; one-hot or zero.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_wr_data`  out  DATA_WIDTH  FIFO write data.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current grant holder.
- `busy`  out  1  high while a grant is held.

## Operation
- FSM with two states:
  - ARB: wait for any `req_valid`.
  - GRANT: the port is owned by `grant_id`.
- ARB:
  - Search round-robin starting at `last_grant+1` (mod NUM_REQ).
  - The first requester with `req_valid` high is registered as `grant_id`; go to GRANT on the next edge.
  - `last_grant` resets to NUM_REQ-1, so requester 0 wins first after reset.
- GRANT:
  - A beat transfers in any cycle where `req_valid[grant_id]` is high and `fifo_full` is low.
  - On a transfer, `fifo_wr_en`=1, `req_ready[grant_id]`=1 and `fifo_wr_data`=`req_data[grant_id]`, all combinational in the same cycle.
  - Each transfer increments `beat_cnt`, a register of width $clog2(MAX_BURST+1) that is cleared on entry to GRANT.
- A grant ends (return to ARB, `last_grant` <= `grant_id`) on the edge after any of:
  - a transfer with `req_last[grant_id]`=1;
  - a transfer that brings `beat_cnt` to MAX_BURST;
  - `idle_cnt` reaching IDLE_TIMEOUT.
- `idle_cnt` counts consecutive GRANT cycles with `req_valid[grant_id]` low. It clears on any cycle where that valid is high.
- Cycles with `fifo_full`=1 and valid high are back-pressure, not idle. They are neither a timeout cycle nor a transfer.
- A packet cut off by MAX_BURST or by the timeout resumes in a later grant. The arbiter does not track packet boundaries across grants.
- Outputs while no transfer is happening: `fifo_wr_en`=0, all `req_ready`=0, `fifo_wr_data`=0.
- `busy`=1 exactly in GRANT.
- Non-granted requesters never see `req_ready`, whatever the value of `fifo_full`.

## Timing
- Reset values: state ARB, `grant_id`=0, `busy`=0, `beat_cnt`=0, `idle_cnt`=0, `last_grant`=NUM_REQ-1.
- While `wr_rst_n` is low, `fifo_wr_en`, `req_ready` and `fifo_wr_data` are forced to 0 combinationally, even if the state is still GRANT before the reset edge.
- Reset mid-burst drops the grant with no further write. The partially written packet stays in the FIFO.
- Arbitration latency: `req_valid` high in ARB at cycle t gives `busy`=1 and the first possible transfer at cycle t+1.
- Each grant is followed by exactly one ARB cycle before the next grant. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- `fifo_full` is sampled combinationally in the same cycle as `fifo_wr_en`. The arbiter never asserts `fifo_wr_en` while `fifo_full`=1, so no write is dropped by the FIFO.
- The last-beat and MAX_BURST conditions can hit on the same transfer: one release, no double count.
- Timeout: `idle_cnt` == IDLE_TIMEOUT ends the grant on that edge.
- The round-robin pointer advances only on grant release, never on reset or in ARB idle cycles.

## Test plan
- **Reset / idle:** hold `wr_rst_n`=0 for 3 cycles with all `req_valid`=1 -> `fifo_wr_en`=0, `req_ready`=0, `busy`=0 throughout. After release, requester 0 is granted 1 cycle later.
- **Round-robin fairness:** all 4 requesters stream 2-beat packets (data = 0xi0, 0xi1) -> FIFO write order 0x00,0x01,0x10,0x11,0x20,0x21,0x30,0x31,0x00…, with 1 ARB cycle between packets.
- **MAX_BURST cut:** MAX_BURST=8; requester 2 sends a 12-beat packet while requester 3 is also valid -> 8 beats from req 2, then requester 3's packet, then req 2's remaining 4 beats.
- **Back-pressure:** `fifo_full` high for cycles 3-6 of a 5-beat burst -> no `fifo_wr_en` or `req_ready` in those cycles; all 5 beats written in order, none lost; no timeout.
- **Timeout:** IDLE_TIMEOUT=4; requester 1 sends 1 non-last beat, then drops valid while requester 0 is valid -> grant released 4 cycles after valid drops; requester 0 granted on the next cycle.
- **Reset mid-burst:** pulse `wr_rst_n` low during beat 3 of 6 from requester 1 -> beats 1-2 written; no writes during reset; next grant goes to requester 0 (pointer reset).
